seg_display_scan: RTL and testbench

//  Parametrised successor to the fixed 4-digit LED driver: time-multiplexes N hex digits onto one
//  7-segment bus. Adds tear-free double-buffered loads, leading-zero blanking, per-digit decimal

---
 rtl/seg_display_scan_pkg.sv | 22 ++
 rtl/seg_display_scan_if.sv | 26 ++
 rtl/seg_display_scan_hex7seg.sv | 9 +
 rtl/seg_display_scan.sv | 112 +++++++++++
 tb/tb_seg_display_scan.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_scan_pkg.sv
// Shared glyph table and polarity helper for the multiplexed
// 7-segment scanner.
package seg_display_scan_pkg;

  // Active-high {G,F,E,D,C,B,A}; b and d are lowercase glyphs
  localparam logic [6:0] HEX_GLYPH [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] pol7(
    input logic [6:0] v,
    input bit         lo
  );
    return lo ? ~v : v;
  endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Load/brightness inputs and multiplexed display pins of the
// segment scanner.
interface seg_display_scan_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] num;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                lzb;
  logic [BRIGHT_W-1:0] bright;
  logic [DIGITS-1:0]   ds_en;
  logic [6:0]          ds_seg;
  logic                ds_dp;
  logic                frame;

  modport master (
    output num, dp, load, lzb, bright,
    input  ds_en, ds_seg, ds_dp, frame
  );

  modport slave (
    input  num, dp, load, lzb, bright,
    output ds_en, ds_seg, ds_dp, frame
  );
endinterface

// File: rtl/seg_display_scan_hex7seg.sv
// Nibble to active-high 7-segment glyph, purely combinational.
module seg_display_scan_hex7seg (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  import seg_display_scan_pkg::*;

  assign seg_o = HEX_GLYPH[nib_i];
endmodule

// File: rtl/seg_display_scan.sv
// N-digit time-multiplexed hex display driver with shadow load,
// leading-zero blanking, PWM dimming and inter-digit dead time.
module seg_display_scan #(
  parameter int DIGITS     = 4,
  parameter int DIV_W      = 16,
  parameter int SLOT_LEN   = 50000,
  parameter int BRIGHT_W   = 4,
  parameter bit SEG_ACT_LO = 1'b1,
  parameter bit EN_ACT_LO  = 1'b1
) (
  input logic clk_i,
  input logic rst_i,
  seg_display_scan_if.slave bus
);
  import seg_display_scan_pkg::*;

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] SLOT_LAST = DIV_W'(SLOT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    slot_q, slot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BRIGHT_W-1:0] pwm_q;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   sdp_q, sdp_d;
  logic [DIGITS-1:0]   ddp_q, ddp_d;
  logic                pend_q, pend_d;

  logic [DIGITS-1:0]   en_q, en_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_q;

  logic                slot_wrap, boundary;
  logic                lit, blank, run;
  logic [DIGITS-1:0]   lz;
  logic [3:0]          nib;
  logic [6:0]          glyph;

  seg_display_scan_hex7seg u_dec (
    .nib_i (nib),
    .seg_o (glyph)
  );

  always_comb begin
    slot_wrap = (slot_q == SLOT_LAST);
    boundary  = slot_wrap && (idx_q == IDX_LAST);
    slot_d    = slot_wrap ? '0 : slot_q + DIV_W'(1);
    idx_d     = idx_q;
    if (slot_wrap)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    // A load on the boundary cycle re-arms pending for the next frame
    pend_d   = bus.load | (pend_q & ~boundary);
    shadow_d = bus.load ? bus.num : shadow_q;
    sdp_d    = bus.load ? bus.dp : sdp_q;
    disp_d   = (boundary && pend_q) ? shadow_q : disp_q;
    ddp_d    = (boundary && pend_q) ? sdp_q : ddp_q;
  end

  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run   = run & (disp_q[4*k +: 4] == 4'd0);
      lz[k] = run;
    end
    nib   = disp_q[4*int'(idx_q) +: 4];
    blank = bus.lzb && (idx_q != '0) && lz[idx_q];
    lit   = (slot_q != '0) &&
            ((&bus.bright) || (pwm_q < bus.bright));
    en_d  = (lit ? (DIGITS'(1) << idx_q) : '0)
            ^ {DIGITS{EN_ACT_LO}};
    seg_d = pol7(blank ? SEG_OFF : glyph, SEG_ACT_LO);
    dp_d  = (~blank & ddp_q[idx_q]) ^ SEG_ACT_LO;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q   <= '0;
      idx_q    <= '0;
      pwm_q    <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      disp_q   <= '0;
      ddp_q    <= '0;
      pend_q   <= 1'b0;
      en_q     <= {DIGITS{EN_ACT_LO}};
      seg_q    <= {7{SEG_ACT_LO}};
      dp_q     <= SEG_ACT_LO;
      frame_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      pwm_q    <= pwm_q + BRIGHT_W'(1);
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      disp_q   <= disp_d;
      ddp_q    <= ddp_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      frame_q  <= boundary;
    end
  end

  assign bus.ds_en  = en_q;
  assign bus.ds_seg = seg_q;
  assign bus.ds_dp  = dp_q;
  assign bus.frame  = frame_q;
endmodule

// File: tb/tb_seg_display_scan.sv
// Randomized bench for seg_display_scan against a frame-time
// reference model (4 digits, 4-clock slots, 4-bit brightness).
module tb_seg_display_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk  = 0;
  int   pass = 0;

  always #5 clk = ~clk;

  seg_display_scan_if #(.DIGITS(4), .BRIGHT_W(4)) bus ();
  seg_display_scan_if #(.DIGITS(4), .BRIGHT_W(4)) bus64 ();

  seg_display_scan #(
    .DIGITS(4), .DIV_W(16), .SLOT_LEN(4), .BRIGHT_W(4),
    .SEG_ACT_LO(1'b1), .EN_ACT_LO(1'b1)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  seg_display_scan #(
    .DIGITS(4), .DIV_W(16), .SLOT_LEN(64), .BRIGHT_W(4),
    .SEG_ACT_LO(1'b1), .EN_ACT_LO(1'b1)
  ) u_dut64 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus64.slave)
  );

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Reference model: position in the scan derives from n, the
  // number of clocks since reset; expected pins for the state at n
  // become visible after that clock.
  int          n = 0;
  int          m_slot, m_dig;
  bit          m_lit, m_blank;
  logic [15:0] m_sh = '0, m_dis = '0;
  logic [3:0]  m_sdp = '0, m_ddp = '0;
  bit          m_pend = 0;
  logic [3:0]  e_en = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1, e_fr = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      n = 0; m_sh = '0; m_dis = '0; m_sdp = '0; m_ddp = '0;
      m_pend = 0; e_en = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      e_fr = 1'b0;
    end else begin
      m_slot  = n % 4;
      m_dig   = (n / 4) % 4;
      m_lit   = (m_slot != 0) &&
                (bus.bright == 4'hF || (n % 16) < int'(bus.bright));
      m_blank = bus.lzb && m_dig != 0 && (m_dis >> (4 * m_dig)) == 0;
      e_en    = m_lit ? ~(4'b0001 << m_dig) : 4'hF;
      e_seg   = m_blank ? 7'h7F : ~glyph(m_dis[4*m_dig +: 4]);
      e_dp    = m_blank ? 1'b1 : ~m_ddp[m_dig];
      e_fr    = (n % 16) == 15;
      if (e_fr) begin
        if (m_pend) begin m_dis = m_sh; m_ddp = m_sdp; end
        m_pend = 0;
      end
      if (bus.load) begin
        m_sh = bus.num; m_sdp = bus.dp; m_pend = 1;
      end
      n++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int first, second;
    rst = 1'b1;
    repeat (3) step();
    chk++;
    if ({bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame} !==
        {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_out got=%h/%h/%b/%b exp=f/7f/1/0",
               bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame);
    else pass++;
    rst = 1'b0;
    step();
    chk++;
    if (bus.ds_en !== 4'hF)
      $display("FAIL first_dead got=%h exp=f", bus.ds_en);
    else pass++;
    step();
    chk++;
    if (bus.ds_en !== 4'hE)
      $display("FAIL first_lit got=%h exp=e", bus.ds_en);
    else pass++;
    first = -1; second = -1;
    for (int c = 3; c <= 40; c++) begin
      step();
      chk++;
      if ({bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame} !==
          {e_en, e_seg, e_dp, e_fr})
        $display("FAIL scan_model n=%0d got=%h exp=%h", n,
                 {bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame},
                 {e_en, e_seg, e_dp, e_fr});
      else pass++;
      if (bus.frame === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    chk++;
    if (first != 16 || second != 32)
      $display("FAIL frame_period got=%0d,%0d exp=16,32",
               first, second);
    else pass++;
  endtask

  task automatic sync_to(input int phase);
    for (int c = 0; c < 16 && (n % 16) != phase; c++) begin
      step();
      chk++;
      if ({bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame} !==
          {e_en, e_seg, e_dp, e_fr})
        $display("FAIL sync_model n=%0d got=%h exp=%h", n,
                 {bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame},
                 {e_en, e_seg, e_dp, e_fr});
      else pass++;
    end
  endtask

  task automatic load(input logic [15:0] v);
    bus.num = v; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic to_frame(input string tag);
    bit seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      chk++;
      if ({bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame} !==
          {e_en, e_seg, e_dp, e_fr})
        $display("FAIL %s_model n=%0d got=%h exp=%h", tag, n,
                 {bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame},
                 {e_en, e_seg, e_dp, e_fr});
      else pass++;
      seen = (bus.frame === 1'b1);
    end
    chk++;
    if (!seen) $display("FAIL %s_frame_timeout got=0 exp=1", tag);
    else pass++;
  endtask

  task automatic test_double_buffer();
    bus.lzb = 1'b0; bus.bright = 4'hF; bus.dp = 4'b0000;
    sync_to(4);
    load(16'h12AF);
    to_frame("buf");
    step();
    chk++;
    if (bus.ds_seg !== 7'h0E)
      $display("FAIL buf_digit0 got=%h exp=0e", bus.ds_seg);
    else pass++;
    repeat (12) step();
    chk++;
    if (bus.ds_seg !== 7'h79)
      $display("FAIL buf_digit3 got=%h exp=79", bus.ds_seg);
    else pass++;
    sync_to(4);
    load(16'h1111);
    sync_to(8);
    load(16'h2222);
    to_frame("lastwins");
    step();
    chk++;
    if (bus.ds_seg !== 7'h24)
      $display("FAIL last_wins got=%h exp=24", bus.ds_seg);
    else pass++;
  endtask

  task automatic test_boundary_load();
    sync_to(15);
    load(16'h0005);
    chk++;
    if (bus.frame !== 1'b1)
      $display("FAIL bnd_frame got=%b exp=1", bus.frame);
    else pass++;
    step();
    chk++;
    if (bus.ds_seg !== 7'h24)
      $display("FAIL bnd_not_yet got=%h exp=24", bus.ds_seg);
    else pass++;
    to_frame("bnd");
    step();
    chk++;
    if (bus.ds_seg !== 7'h12)
      $display("FAIL bnd_later got=%h exp=12", bus.ds_seg);
    else pass++;
  endtask

  task automatic test_lzb();
    bus.lzb = 1'b1;
    sync_to(2);
    load(16'h0042);
    to_frame("lzb");
    for (int s = 0; s < 16; s++) begin
      step();
      chk++;
      if ({bus.ds_en, bus.ds_seg, bus.ds_dp} !== {e_en, e_seg, e_dp})
        $display("FAIL lzb_model s=%0d got=%h exp=%h", s,
                 {bus.ds_en, bus.ds_seg, bus.ds_dp},
                 {e_en, e_seg, e_dp});
      else pass++;
      if (s == 8 || s == 12) begin
        chk++;
        if (bus.ds_seg !== 7'h7F)
          $display("FAIL lzb_blank s=%0d got=%h exp=7f", s, bus.ds_seg);
        else pass++;
      end
    end
    load(16'h0000);
    to_frame("lzb0");
    to_frame("lzb0b");
  endtask

  task automatic test_bright();
    int lit_cnt, exp_cnt;
    bit ok;
    bus.bright = 4'h0;
    ok = 1;
    for (int c = 0; c < 32; c++) begin
      step();
      if (bus.ds_en !== 4'hF) ok = 0;
    end
    chk++;
    if (!ok) $display("FAIL bright0 got=lit exp=dark");
    else pass++;
    bus.bright = 4'hF;
    step();
    for (int c = 0; c < 32; c++) begin
      step();
      chk++;
      if (bus.ds_en !== e_en || (((n - 1) % 4 != 0) && bus.ds_en == 4'hF))
        $display("FAIL bright_full n=%0d got=%h exp=%h",
                 n, bus.ds_en, e_en);
      else pass++;
    end
    exp_cnt = 0;
    for (int s = 1; s < 64; s++) if ((s % 16) < 4) exp_cnt++;
    for (int c = 0; c < 64 && (n % 64) != 1; c++) step();
    lit_cnt = 0;
    ok = 1;
    for (int s = 0; s < 64; s++) begin
      if (bus64.ds_en !== 4'hF) lit_cnt++;
      if (s == 0 && bus64.ds_en !== 4'hF) ok = 0;
      step();
    end
    chk++;
    if (!ok || lit_cnt != exp_cnt)
      $display("FAIL pwm_duty got=%0d dead_ok=%0b exp=%0d dead_ok=1",
               lit_cnt, ok, exp_cnt);
    else pass++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      bus.lzb    = 1'($urandom_range(0, 1));
      bus.bright = 4'($urandom_range(0, 15));
      for (int c = 0; c < 16; c++) begin
        bus.load = ($urandom_range(0, 3) == 0);
        bus.num  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
        bus.dp   = 4'($urandom);
        step();
        chk++;
        if ({bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame} !==
            {e_en, e_seg, e_dp, e_fr})
          $display("FAIL rand_model n=%0d got=%h exp=%h", n,
                   {bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame},
                   {e_en, e_seg, e_dp, e_fr});
        else pass++;
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit fr_seen = 0;
    bus.lzb = 1'b0; bus.bright = 4'hF;
    sync_to(5);
    load(16'h7777);
    sync_to(10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk++;
    if ({bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame} !==
        {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL midrst_out got=%h/%h/%b/%b exp=f/7f/1/0",
               bus.ds_en, bus.ds_seg, bus.ds_dp, bus.frame);
    else pass++;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (bus.frame === 1'b1) fr_seen = 1;
    end
    chk++;
    if (fr_seen) $display("FAIL midrst_frame got=1 exp=0");
    else pass++;
    to_frame("midrst");
    step();
    chk++;
    if (bus.ds_seg !== 7'h40)
      $display("FAIL midrst_cleared got=%h exp=40", bus.ds_seg);
    else pass++;
  endtask

  initial begin
    bus.num = '0; bus.dp = '0; bus.load = 1'b0;
    bus.lzb = 1'b0; bus.bright = 4'hF;
    bus64.num = '0; bus64.dp = '0; bus64.load = 1'b0;
    bus64.lzb = 1'b0; bus64.bright = 4'h4;
    test_reset();
    test_double_buffer();
    test_boundary_load();
    test_lzb();
    test_bright();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
